// File: rtl/mem_arb_pkg.sv
// Shared constants for the IF/MEM single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_ACC = 2'd1,
    IF_ACC  = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
  localparam int unsigned TMO_CNT_W    = 16;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Access watchdog counter; present only when MEMPORT_TIMEOUT_EN is defined.
`ifdef MEMPORT_TIMEOUT_EN
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = TMO_CNT_W,
  parameter int unsigned LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  logic [WIDTH-1:0] r_cnt;

  // Expires in the LIMIT-th enabled cycle after a load.
  assign o_expired = i_en && (r_cnt == WIDTH'(LIMIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between IF fetch and MEM load/store (MEM wins).
// Optional access watchdog enabled by defining MEMPORT_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ready,
  output logic              o_port_req,
  output logic              o_port_we,
  output logic [ADDR_W-1:0] o_port_addr,
  output logic [DATA_W-1:0] o_port_wdata,
  input  logic              i_port_ack,
  input  logic [DATA_W-1:0] i_port_rdata,
  output logic              o_stall_if,
  output logic              o_stall_mem,
  output logic              o_err_timeout
);

  arb_state_t        r_state;
  logic              r_gnt;
  logic              r_port_req;
  logic              r_port_we;
  logic [ADDR_W-1:0] r_port_addr;
  logic [DATA_W-1:0] r_port_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_ready;
  logic              r_mem_ready;

  logic              w_mem_req;
  logic              w_in_acc;
  logic              w_grant;
  logic              w_expired;

  assign w_mem_req = i_mem_read | i_mem_write;
  assign w_in_acc  = (r_state == MEM_ACC) || (r_state == IF_ACC);
  assign w_grant   = (r_state == IDLE) && (w_mem_req || i_if_req);

`ifdef MEMPORT_TIMEOUT_EN
  logic r_err_timeout;

  arb_timeout_ctr #(
    .WIDTH (TMO_CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_grant),
    .i_en      (w_in_acc),
    .o_expired (w_expired)
  );

  assign o_err_timeout = r_err_timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_timeout <= 1'b0;
    end else if (w_in_acc && !i_port_ack && w_expired) begin
      r_err_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign o_err_timeout    = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_gnt        <= GNT_IF;
      r_port_req   <= 1'b0;
      r_port_we    <= 1'b0;
      r_port_addr  <= '0;
      r_port_wdata <= '0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mem_req) begin
            // read+write together is treated as a write
            r_port_addr  <= i_mem_addr;
            r_port_wdata <= i_mem_wdata;
            r_port_we    <= i_mem_write;
            r_port_req   <= 1'b1;
            r_gnt        <= GNT_MEM;
            r_state      <= MEM_ACC;
          end else if (i_if_req) begin
            r_port_addr <= i_if_addr;
            r_port_we   <= 1'b0;
            r_port_req  <= 1'b1;
            r_gnt       <= GNT_IF;
            r_state     <= IF_ACC;
          end
        end
        MEM_ACC, IF_ACC: begin
          if (i_port_ack) begin
            r_port_req <= 1'b0;
            if (r_gnt == GNT_MEM) begin
              r_mem_rdata <= i_port_rdata;
              r_mem_ready <= 1'b1;
            end else begin
              r_if_rdata <= i_port_rdata;
              r_if_ready <= 1'b1;
            end
            r_state <= RESP;
          end else if (w_expired) begin
            r_port_req <= 1'b0;
            if (r_gnt == GNT_MEM) begin
              r_mem_rdata <= DATA_W'(TIMEOUT_DATA);
              r_mem_ready <= 1'b1;
            end else begin
              r_if_rdata <= DATA_W'(TIMEOUT_DATA);
              r_if_ready <= 1'b1;
            end
            r_state <= RESP;
          end
        end
        // Ready pulse is visible here; no grant so the pipeline can advance first.
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_port_req   = r_port_req;
  assign o_port_we    = r_port_we;
  assign o_port_addr  = r_port_addr;
  assign o_port_wdata = r_port_wdata;
  assign o_if_rdata   = r_if_rdata;
  assign o_if_ready   = r_if_ready;
  assign o_mem_rdata  = r_mem_rdata;
  assign o_mem_ready  = r_mem_ready;

  assign o_stall_mem = w_mem_req & ~r_mem_ready;
  assign o_stall_if  = (i_if_req & ~r_if_ready) | o_stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs driven after posedge,
// outputs checked on negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        port_req;
  logic        port_we;
  logic [31:0] port_addr;
  logic [31:0] port_wdata;
  logic        port_ack;
  logic [31:0] port_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_if_req      (if_req),
    .i_if_addr     (if_addr),
    .o_if_rdata    (if_rdata),
    .o_if_ready    (if_ready),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_mem_addr    (mem_addr),
    .i_mem_wdata   (mem_wdata),
    .o_mem_rdata   (mem_rdata),
    .o_mem_ready   (mem_ready),
    .o_port_req    (port_req),
    .o_port_we     (port_we),
    .o_port_addr   (port_addr),
    .o_port_wdata  (port_wdata),
    .i_port_ack    (port_ack),
    .i_port_rdata  (port_rdata),
    .o_stall_if    (stall_if),
    .o_stall_mem   (stall_mem),
    .o_err_timeout (err_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_wdata = '0; port_ack = 1'b0; port_rdata = '0;

    // Reset state
    step(); step();
    samp();
    chk("rst_port_req", port_req, 0);     chk("rst_port_we", port_we, 0);
    chk("rst_if_ready", if_ready, 0);     chk("rst_mem_ready", mem_ready, 0);
    chk("rst_err", err_timeout, 0);       chk("rst_port_addr", port_addr, 0);
    chk("rst_port_wdata", port_wdata, 0); chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);   chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_mem", stall_mem, 0);

    // Single fetch, ack two cycles after port_req rises
    step(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h40;
    samp(); chk("f0_stall_if", stall_if, 1); chk("f0_req", port_req, 0);
    step();
    samp(); chk("f1_req", port_req, 1); chk("f1_addr", port_addr, 32'h40);
    chk("f1_we", port_we, 0);
    step(); if_addr = 32'h80;
    samp(); chk("f2_addr_stable", port_addr, 32'h40); chk("f2_stall_if", stall_if, 1);
    step(); port_ack = 1'b1; port_rdata = 32'h8C010004;
    samp(); chk("f3_req", port_req, 1); chk("f3_if_ready", if_ready, 0);
    step(); port_ack = 1'b0; port_rdata = '0;
    samp(); chk("f4_if_ready", if_ready, 1); chk("f4_if_rdata", if_rdata, 32'h8C010004);
    chk("f4_stall_if", stall_if, 0); chk("f4_req", port_req, 0);
    step(); if_req = 1'b0;
    samp(); chk("f5_if_ready", if_ready, 0); chk("f5_req", port_req, 0);

    // Store with immediate ack
    step(); mem_write = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h12345678;
    samp(); chk("s0_stall_mem", stall_mem, 1);
    step(); port_ack = 1'b1;
    samp(); chk("s1_req", port_req, 1); chk("s1_we", port_we, 1);
    chk("s1_wdata", port_wdata, 32'h12345678); chk("s1_addr", port_addr, 32'h100);
    chk("s1_stall_mem", stall_mem, 1);
    step(); port_ack = 1'b0;
    samp(); chk("s2_mem_ready", mem_ready, 1); chk("s2_stall_mem", stall_mem, 0);
    chk("s2_req", port_req, 0);
    step(); mem_write = 1'b0;
    samp(); chk("s3_mem_ready", mem_ready, 0);

    // Contention: MEM read wins, IF follows after RESP
    step(); if_req = 1'b1; if_addr = 32'h44; mem_read = 1'b1; mem_addr = 32'h200;
    samp(); chk("c0_stall_if", stall_if, 1); chk("c0_stall_mem", stall_mem, 1);
    step(); port_ack = 1'b1; port_rdata = 32'hA5A5A5A5;
    samp(); chk("c1_addr", port_addr, 32'h200); chk("c1_we", port_we, 0);
    chk("c1_stall_if", stall_if, 1);
    step(); port_ack = 1'b0; port_rdata = '0;
    samp(); chk("c2_mem_ready", mem_ready, 1); chk("c2_mem_rdata", mem_rdata, 32'hA5A5A5A5);
    chk("c2_if_ready", if_ready, 0); chk("c2_stall_if", stall_if, 1);
    chk("c2_stall_mem", stall_mem, 0); chk("c2_req", port_req, 0);
    step(); mem_read = 1'b0;
    samp(); chk("c3_req", port_req, 0); chk("c3_stall_if", stall_if, 1);
    step(); port_ack = 1'b1; port_rdata = 32'h11112222;
    samp(); chk("c4_req", port_req, 1); chk("c4_addr", port_addr, 32'h44);
    chk("c4_we", port_we, 0);
    step(); port_ack = 1'b0; port_rdata = '0;
    samp(); chk("c5_if_ready", if_ready, 1); chk("c5_if_rdata", if_rdata, 32'h11112222);
    chk("c5_stall_if", stall_if, 0);
    step(); if_req = 1'b0;
    samp(); chk("c6_if_ready", if_ready, 0);

    // Reset mid-access, then a stray ack
    step(); mem_read = 1'b1; mem_addr = 32'h300;
    samp();
    step();
    samp(); chk("r1_req", port_req, 1);
    step(); rst = 1'b1;
    samp();
    step(); rst = 1'b0; mem_read = 1'b0; port_ack = 1'b1; port_rdata = 32'hFFFF0000;
    samp(); chk("r3_req", port_req, 0); chk("r3_mem_ready", mem_ready, 0);
    chk("r3_addr", port_addr, 0);
    step(); port_ack = 1'b0; port_rdata = '0;
    samp(); chk("r4_mem_ready", mem_ready, 0); chk("r4_if_ready", if_ready, 0);
    chk("r4_mem_rdata", mem_rdata, 0); chk("r4_req", port_req, 0);

    // Illegal read+write is a write
    step(); mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h180; mem_wdata = 32'hCAFEF00D;
    samp();
    step(); port_ack = 1'b1;
    samp(); chk("i1_we", port_we, 1); chk("i1_wdata", port_wdata, 32'hCAFEF00D);
    step(); port_ack = 1'b0;
    samp(); chk("i2_mem_ready", mem_ready, 1);
    step(); mem_read = 1'b0; mem_write = 1'b0;
    samp();

    // Unacknowledged read
    step(); mem_read = 1'b1; mem_addr = 32'h400;
    samp();
`ifdef MEMPORT_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      step();
      samp();
      if (k == 1 || k == 15) chk("t_req_held", port_req, 1);
    end
    step();
    samp(); chk("t16_req", port_req, 0); chk("t16_err", err_timeout, 1);
    chk("t16_mem_ready", mem_ready, 1); chk("t16_mem_rdata", mem_rdata, 32'hDEADBEEF);
    step(); mem_read = 1'b0;
    samp(); chk("t17_err_sticky", err_timeout, 1); chk("t17_mem_ready", mem_ready, 0);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    samp(); chk("t_err_cleared", err_timeout, 0);
`else
    for (int k = 1; k <= 40; k++) begin
      step();
      samp();
      if (k == 15 || k == 16 || k == 40) begin
        chk("t_req_held", port_req, 1);
        chk("t_err_zero", err_timeout, 0);
        chk("t_no_ready", mem_ready, 0);
      end
    end
    step(); port_ack = 1'b1; port_rdata = 32'h0BADF00D;
    samp();
    step(); port_ack = 1'b0;
    samp(); chk("t_late_ready", mem_ready, 1); chk("t_late_rdata", mem_rdata, 32'h0BADF00D);
    step(); mem_read = 1'b0;
    samp();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
